epass_reader: RTL and testbench

- Roadside E-pass tag reader. Produces the `valid_Epass` code and the pass handshake that the lane barrier controller consumes.
- Opens a read window on a vehicle trigger. Receives one UART-framed tag packet from the antenna demodulator, checks it, and deducts the toll from the tag balance.
- Holds a 2-bit verdict until the lane controller acknowledges it.

---
 rtl/epass_reader.sv | 199 +++++++++++++++++++
 tb/tb_epass_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/epass_reader.sv
// Roadside E-pass tag reader: UART-framed tag packet receiver, checksum/balance check and verdict handshake.
// Optional feature macro: EPASS_BLACKLIST_EN (rejects the tag whose ID equals BLACKLIST_ID).
module epass_reader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [15:0] TOLL         = 16'd25,
  parameter int          WINDOW_CYC   = 4096
`ifdef EPASS_BLACKLIST_EN
  , parameter logic [15:0] BLACKLIST_ID = 16'hFFFF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        rx_serial,
  input  logic        ack,
  output logic [1:0]  valid_Epass,
  output logic        result_vld,
  output logic [15:0] tag_id,
  output logic [15:0] new_balance,
  output logic        busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int WIN_W = $clog2(WINDOW_CYC + 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYC);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [2:0] {IDLE, WAIT_SOF, RX_BODY, CHECK, RESULT} state_t;

  rxState_t          r_rxState, w_rxNext;
  state_t            r_state, w_next;

  logic              r_rxMeta, r_rxSync, r_rxPrev;
  logic [CNT_W-1:0]  r_clkCnt;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;
  logic              r_byteVld, r_frameErr;

  logic [WIN_W-1:0]  r_winCnt;
  logic [2:0]        r_byteIdx;
  logic [7:0]        r_body [5];
  logic [1:0]        r_validEpass;
  logic [15:0]       r_tagId, r_newBalance;

  logic              w_fallEdge, w_sample, w_timeout, w_csumOk, w_blacklisted;
  logic [15:0]       w_rxId, w_rxBalance, w_newBal;
  logic [1:0]        w_verdict;
  logic              w_verdictLoad, w_checkLoad;

  assign w_fallEdge = r_rxPrev & ~r_rxSync;
  assign w_sample   = ((r_rxState == RX_START) && (r_clkCnt == HALF_CNT)) ||
                      (((r_rxState == RX_DATA) || (r_rxState == RX_STOP)) && (r_clkCnt == FULL_CNT));

  // Synchroniser flops idle high so that reset never looks like a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
      r_rxPrev <= 1'b1;
      r_rxState <= RX_IDLE;
    end else begin
      r_rxMeta <= rx_serial;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
      r_rxState <= w_rxNext;
    end
  end

  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE:  if (w_fallEdge) w_rxNext = RX_START;
      RX_START: if (w_sample) w_rxNext = r_rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_sample && (r_bitIdx == 3'd7)) w_rxNext = RX_STOP;
      RX_STOP:  if (w_sample) w_rxNext = RX_IDLE;
      default:  w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clkCnt   <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_byteVld  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_byteVld  <= 1'b0;
      r_frameErr <= 1'b0;
      if ((r_rxState == RX_IDLE) || w_sample) r_clkCnt <= '0;
      else r_clkCnt <= r_clkCnt + 1'b1;
      if (r_rxState == RX_START) r_bitIdx <= '0;
      if ((r_rxState == RX_DATA) && w_sample) begin
        r_shift  <= {r_rxSync, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 1'b1;
      end
      if ((r_rxState == RX_STOP) && w_sample) begin
        r_byteVld  <= r_rxSync;
        r_frameErr <= ~r_rxSync;
      end
    end
  end

  assign w_rxId      = {r_body[0], r_body[1]};
  assign w_rxBalance = {r_body[2], r_body[3]};
  assign w_csumOk    = ((r_body[0] ^ r_body[1] ^ r_body[2] ^ r_body[3]) == r_body[4]);
  assign w_timeout   = (r_winCnt == '0);

`ifdef EPASS_BLACKLIST_EN
  assign w_blacklisted = (w_rxId == BLACKLIST_ID);
`else
  assign w_blacklisted = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The final frame byte is tested before the timeout so a simultaneous expiry still reaches CHECK
  always_comb begin
    w_next        = r_state;
    w_verdict     = 2'b00;
    w_verdictLoad = 1'b0;
    w_checkLoad   = 1'b0;
    w_newBal      = w_rxBalance;
    case (r_state)
      IDLE: if (trigger) w_next = WAIT_SOF;
      WAIT_SOF: begin
        if (r_frameErr || w_timeout) begin
          w_next = RESULT;
          w_verdict = 2'b11;
          w_verdictLoad = 1'b1;
        end else if (r_byteVld && (r_shift == 8'hA5)) begin
          w_next = RX_BODY;
        end
      end
      RX_BODY: begin
        if (r_byteVld && (r_byteIdx == 3'd4)) begin
          w_next = CHECK;
        end else if (r_frameErr || w_timeout) begin
          w_next = RESULT;
          w_verdict = 2'b11;
          w_verdictLoad = 1'b1;
        end
      end
      CHECK: begin
        w_next = RESULT;
        w_verdictLoad = 1'b1;
        w_checkLoad = 1'b1;
        if (!w_csumOk || w_blacklisted) begin
          w_verdict = 2'b11;
        end else if (w_rxBalance < TOLL) begin
          w_verdict = 2'b10;
        end else begin
          w_verdict = 2'b01;
          w_newBal = w_rxBalance - TOLL;
        end
      end
      RESULT: if (ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_winCnt     <= '0;
      r_byteIdx    <= '0;
      for (int i = 0; i < 5; i++) r_body[i] <= '0;
      r_validEpass <= 2'b00;
      r_tagId      <= '0;
      r_newBalance <= '0;
    end else begin
      if ((r_state == IDLE) && trigger) r_winCnt <= WIN_LOAD;
      else if (((r_state == WAIT_SOF) || (r_state == RX_BODY)) && !w_timeout)
        r_winCnt <= r_winCnt - 1'b1;
      if (r_state == WAIT_SOF) r_byteIdx <= '0;
      if ((r_state == RX_BODY) && r_byteVld) begin
        r_body[r_byteIdx] <= r_shift;
        r_byteIdx <= r_byteIdx + 1'b1;
      end
      if (w_verdictLoad) r_validEpass <= w_verdict;
      else if ((r_state == IDLE) || ((r_state == RESULT) && ack)) r_validEpass <= 2'b00;
      if (w_checkLoad) begin
        r_tagId      <= w_rxId;
        r_newBalance <= w_newBal;
      end
    end
  end

  assign valid_Epass = r_validEpass;
  assign result_vld  = (r_state == RESULT);
  assign tag_id      = r_tagId;
  assign new_balance = r_newBalance;
  assign busy        = (r_state == WAIT_SOF) || (r_state == RX_BODY) || (r_state == CHECK);

endmodule

// File: tb/tb_epass_reader.sv
// Directed self-checking bench for epass_reader: good/low/bad frames, timeout, glitch/noise, framing, reset.
module tb_epass_reader;

  localparam int CPB = 16;
  localparam int WIN = 4096;
`ifdef EPASS_BLACKLIST_EN
  localparam logic [1:0]  GOOD_V   = 2'b11;
  localparam logic [15:0] GOOD_BAL = 16'h0064;
  localparam logic [1:0]  LOW_V    = 2'b11;
`else
  localparam logic [1:0]  GOOD_V   = 2'b01;
  localparam logic [15:0] GOOD_BAL = 16'h004B;
  localparam logic [1:0]  LOW_V    = 2'b10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        rx_serial = 1'b1;
  logic        ack = 1'b0;
  logic [1:0]  valid_Epass;
  logic        result_vld;
  logic [15:0] tag_id;
  logic [15:0] new_balance;
  logic        busy;

  int nVec = 0;
  int nMis = 0;

  epass_reader #(
    .CLKS_PER_BIT(CPB),
    .TOLL(16'd25),
    .WINDOW_CYC(WIN)
`ifdef EPASS_BLACKLIST_EN
    , .BLACKLIST_ID(16'h1234)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .rx_serial(rx_serial),
    .ack(ack),
    .valid_Epass(valid_Epass),
    .result_vld(result_vld),
    .tag_id(tag_id),
    .new_balance(new_balance),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic holdBit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(b[i]);
    holdBit(stopBit);
    holdBit(1'b1);
  endtask

  task automatic sendFrame(input logic [7:0] idHi, idLo, balHi, balLo, csum);
    sendByte(8'hA5, 1'b1);
    sendByte(idHi, 1'b1);
    sendByte(idLo, 1'b1);
    sendByte(balHi, 1'b1);
    sendByte(balLo, 1'b1);
    sendByte(csum, 1'b1);
  endtask

  task automatic applyStimulus();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int n = 0;
    while (result_vld !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_seen"}, {31'd0, result_vld}, 32'd1);
  endtask

  task automatic doAck(input string tag);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checkOutput({tag, "_ackV"}, {30'd0, valid_Epass}, 32'd0);
    checkOutput({tag, "_ackR"}, {31'd0, result_vld}, 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    checkOutput("rst_valid", {30'd0, valid_Epass}, 32'd0);
    checkOutput("rst_rvld", {31'd0, result_vld}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame with hold-until-ack and trigger/ack interplay
    applyStimulus();
    checkOutput("good_busy", {31'd0, busy}, 32'd1);
    sendFrame(8'h12, 8'h34, 8'h00, 8'h64, 8'h42);
    waitResult("good");
    checkOutput("good_valid", {30'd0, valid_Epass}, {30'd0, GOOD_V});
    checkOutput("good_tag", {16'd0, tag_id}, 32'h1234);
    checkOutput("good_bal", {16'd0, new_balance}, {16'd0, GOOD_BAL});
    checkOutput("good_busy0", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    applyStimulus();
    checkOutput("good_holdR", {31'd0, result_vld}, 32'd1);
    checkOutput("good_holdV", {30'd0, valid_Epass}, {30'd0, GOOD_V});
    checkOutput("good_trigIgn", {31'd0, busy}, 32'd0);
    trigger = 1'b1;
    doAck("good");
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("good_trigDrop", {31'd0, busy}, 32'd0);

    // Low balance
    applyStimulus();
    sendFrame(8'h12, 8'h34, 8'h00, 8'h0A, 8'h2C);
    waitResult("low");
    checkOutput("low_valid", {30'd0, valid_Epass}, {30'd0, LOW_V});
    checkOutput("low_bal", {16'd0, new_balance}, 32'h000A);
    doAck("low");

    // Bad checksum
    applyStimulus();
    sendFrame(8'h12, 8'h34, 8'h00, 8'h64, 8'h43);
    waitResult("csum");
    checkOutput("csum_valid", {30'd0, valid_Epass}, 32'd3);
    checkOutput("csum_tag", {16'd0, tag_id}, 32'h1234);
    doAck("csum");

    // Window timeout with idle line
    applyStimulus();
    repeat (WIN - 20) @(negedge clk);
    checkOutput("tmo_early_busy", {31'd0, busy}, 32'd1);
    checkOutput("tmo_early_rvld", {31'd0, result_vld}, 32'd0);
    waitResult("tmo");
    checkOutput("tmo_valid", {30'd0, valid_Epass}, 32'd3);
    checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
    doAck("tmo");

    // Glitch plus two noise bytes ahead of SOF
    applyStimulus();
    rx_serial = 1'b0;
    repeat (2) @(negedge clk);
    rx_serial = 1'b1;
    repeat (CPB * 2) @(negedge clk);
    sendByte(8'h3C, 1'b1);
    sendByte(8'h5A, 1'b1);
    sendFrame(8'h12, 8'h34, 8'h00, 8'h64, 8'h42);
    waitResult("noise");
    checkOutput("noise_valid", {30'd0, valid_Epass}, {30'd0, GOOD_V});
    checkOutput("noise_bal", {16'd0, new_balance}, {16'd0, GOOD_BAL});
    doAck("noise");

    // Framing error on the third byte
    applyStimulus();
    sendByte(8'hA5, 1'b1);
    sendByte(8'h12, 1'b1);
    sendByte(8'h34, 1'b0);
    waitResult("frm");
    checkOutput("frm_valid", {30'd0, valid_Epass}, 32'd3);
    repeat (3) @(negedge clk);
    checkOutput("frm_hold", {31'd0, result_vld}, 32'd1);
    doAck("frm");

    // Reset in the middle of BAL_hi, then a clean frame
    applyStimulus();
    sendByte(8'hA5, 1'b1);
    sendByte(8'h12, 1'b1);
    sendByte(8'h34, 1'b1);
    rx_serial = 1'b0;
    repeat (CPB * 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rx_serial = 1'b1;
    checkOutput("mrst_valid", {30'd0, valid_Epass}, 32'd0);
    checkOutput("mrst_rvld", {31'd0, result_vld}, 32'd0);
    checkOutput("mrst_tag", {16'd0, tag_id}, 32'd0);
    checkOutput("mrst_bal", {16'd0, new_balance}, 32'd0);
    checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (CPB * 2) @(negedge clk);
    checkOutput("mrst_idle", {31'd0, busy}, 32'd0);
    applyStimulus();
    sendFrame(8'h12, 8'h34, 8'h00, 8'h64, 8'h42);
    waitResult("after");
    checkOutput("after_valid", {30'd0, valid_Epass}, {30'd0, GOOD_V});
    checkOutput("after_tag", {16'd0, tag_id}, 32'h1234);
    doAck("after");

    // Exact-TOLL balance pays down to zero
    applyStimulus();
    sendFrame(8'h00, 8'h07, 8'h00, 8'h19, 8'h1E);
    waitResult("exact");
    checkOutput("exact_valid", {30'd0, valid_Epass}, 32'd1);
    checkOutput("exact_bal", {16'd0, new_balance}, 32'd0);
    checkOutput("exact_tag", {16'd0, tag_id}, 32'h0007);
    doAck("exact");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
